// File: rtl/gldp_pkg.sv
// Shared helpers for the gldp FRC dither path: Mersenne period, mod-P fold and
// checkerboard phase offset. Widths are passed in so every IN_W can share them.
package gldp_pkg;

    function automatic logic [31:0] period_of(input int in_w);
        return (32'd1 << in_w) - 32'd1;
    endfunction

    localparam int          GLDP_IN_W = 5;
    localparam logic [31:0] GLDP_P    = period_of(GLDP_IN_W);

    // Reduce a value below 2^(2*in_w) modulo 2^in_w-1 without a divider.
    function automatic logic [31:0] mod_mersenne(input logic [31:0] v, input int in_w);
        logic [31:0] p;
        logic [31:0] s;
        p = period_of(in_w);
        s = (v & p) + ((v >> in_w) & p);
        s = (s & p) + (s >> in_w);
        if (s == p) begin
            s = '0;
        end
        return s;
    endfunction

    function automatic logic [31:0] phase_offset(input logic sel, input int in_w);
        return sel ? (period_of(in_w) >> 1) : 32'd0;
    endfunction

endpackage

// File: rtl/gldp_frc_lane.sv
// gldp_frc_lane: one channel of the FRC engine -- level capture, fe*L mod P,
// and the on/off threshold compare.
module gldp_frc_lane
    import gldp_pkg::*;
#(
    parameter int IN_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_in_valid,
    input  logic [IN_W-1:0] i_level,
    input  logic [IN_W-1:0] i_fe,
    input  logic            i_s1_valid,
    output logic            o_valid,
    output logic            o_dither
);
    localparam logic [31:0]   P32 = period_of(IN_W);
    localparam logic [IN_W:0] P_X = (IN_W + 1)'(P32);

    logic [IN_W-1:0]   r_lvl;
    logic              r_v2;
    logic [IN_W-1:0]   r_r;
    logic [IN_W-1:0]   r_l2;
    logic              r_v3;
    logic              r_bit;

    logic [2*IN_W-1:0] w_prod;
    logic [31:0]       w_mod_full;
    logic [IN_W:0]     w_sum;
    logic              w_hit;
    logic              w_unused_mod;

    always_comb begin
        w_prod     = (2 * IN_W)'(i_fe) * (2 * IN_W)'(r_lvl);
        w_mod_full = mod_mersenne(32'(w_prod), IN_W);
        // r + L reaches P exactly L times over P consecutive effective frames
        w_sum      = {1'b0, r_r} + {1'b0, r_l2};
        w_hit      = (w_sum >= P_X);
    end

    assign w_unused_mod = ^w_mod_full[31:IN_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lvl <= '0;
            r_v2  <= 1'b0;
            r_r   <= '0;
            r_l2  <= '0;
            r_v3  <= 1'b0;
            r_bit <= 1'b0;
        end else begin
            if (i_in_valid) begin
                r_lvl <= i_level;
            end
            r_v2 <= i_s1_valid;
            if (i_s1_valid) begin
                r_r  <= w_mod_full[IN_W-1:0];
                r_l2 <= r_lvl;
            end
            r_v3 <= r_v2;
            if (r_v2) begin
                r_bit <= w_hit;
            end
        end
    end

    assign o_valid  = r_v3;
    assign o_dither = r_bit;

endmodule

// File: rtl/gldp_frc.sv
// gldp_frc: CH-channel frame-rate-control dither engine, 3-cycle latency.
// Define GLDP_FRC_SUPERFRAME_INV_EN to swap checkerboard phases every P frames.
module gldp_frc
    import gldp_pkg::*;
#(
    parameter int IN_W = 5,
    parameter int CH   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic               line_start,
    input  logic               in_valid,
    input  logic [CH*IN_W-1:0] in_data,
    input  logic               inv,
    output logic               out_valid,
    output logic [CH-1:0]      out_dither
);
    localparam logic [31:0]     P32    = period_of(IN_W);
    localparam logic [IN_W-1:0] P_LAST = IN_W'(P32 - 32'd1);

    logic [IN_W-1:0] r_fcnt;
    logic            r_sinv;
    logic            r_ypar;
    logic            r_xpar;
    logic [IN_W-1:0] r_fe;
    logic            r_s1_valid;

    logic            w_wrap;
    logic [IN_W-1:0] w_fcnt_nxt;
    logic            w_sinv_nxt;
    logic            w_ypar_nxt;
    logic            w_xpar_cur;
    logic            w_phase;
    logic [31:0]     w_fe_full;
    logic [IN_W-1:0] w_fe;
    logic [CH-1:0]   w_lane_valid;
    logic            w_unused_fe;

    // A pixel arriving with frame/line start already sees the updated counters.
    always_comb begin
        w_wrap     = frame_start && (r_fcnt == P_LAST);
        w_fcnt_nxt = r_fcnt;
        if (frame_start) begin
            w_fcnt_nxt = w_wrap ? '0 : r_fcnt + IN_W'(1);
        end
`ifdef GLDP_FRC_SUPERFRAME_INV_EN
        w_sinv_nxt = r_sinv ^ w_wrap;
`else
        w_sinv_nxt = r_sinv;
`endif
        w_ypar_nxt = frame_start ? 1'b0 : (r_ypar ^ line_start);
        w_xpar_cur = (frame_start || line_start) ? 1'b0 : r_xpar;
        w_phase    = w_xpar_cur ^ w_ypar_nxt ^ inv ^ w_sinv_nxt;
        w_fe_full  = mod_mersenne(32'(w_fcnt_nxt) + phase_offset(w_phase, IN_W), IN_W);
        w_fe       = w_fe_full[IN_W-1:0];
    end

    assign w_unused_fe = ^w_fe_full[31:IN_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fcnt     <= '0;
            r_sinv     <= 1'b0;
            r_ypar     <= 1'b0;
            r_xpar     <= 1'b0;
            r_fe       <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            r_fcnt     <= w_fcnt_nxt;
            r_sinv     <= w_sinv_nxt;
            r_ypar     <= w_ypar_nxt;
            r_xpar     <= in_valid ? ~w_xpar_cur : w_xpar_cur;
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_fe <= w_fe;
            end
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_lane
        gldp_frc_lane #(
            .IN_W (IN_W)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_in_valid (in_valid),
            .i_level    (in_data[c*IN_W +: IN_W]),
            .i_fe       (r_fe),
            .i_s1_valid (r_s1_valid),
            .o_valid    (w_lane_valid[c]),
            .o_dither   (out_dither[c])
        );
    end

    assign out_valid = &w_lane_valid;

endmodule

// File: tb/tb_gldp_frc.sv
// Self-checking bench for gldp_frc: spec-level reference model plus directed
// pattern checks and randomized traffic.
module tb_gldp_frc;
  localparam int IN_W = 5;
  localparam int CH   = 3;
  localparam int P    = 31;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               frame_start = 1'b0;
  logic               line_start = 1'b0;
  logic               in_valid = 1'b0;
  logic [CH*IN_W-1:0] in_data = '0;
  logic               inv = 1'b0;
  logic               out_valid;
  logic [CH-1:0]      out_dither;

  gldp_frc #(.IN_W(IN_W), .CH(CH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .line_start  (line_start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .inv         (inv),
    .out_valid   (out_valid),
    .out_dither  (out_dither)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            due;
    logic [CH-1:0] bits;
  } exp_t;

  exp_t          exp_q[$];
  logic [CH-1:0] act_q[$];
  logic [CH-1:0] last_exp = '0;
  exp_t          cmp_e;
  int            n_checks = 0;
  int            n_errors = 0;

  // reference model state (frame index mod P, line/column parity, superframe flag)
  int m_fcnt = 0, m_ypar = 0, m_xpar = 0, m_sinv = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  // driver: one call = one clock cycle of input
  task automatic px(input logic fs, input logic ls, input logic v,
                    input logic [CH*IN_W-1:0] d, input logic iv);
    int s, fe, lv, r;
    logic [CH-1:0] b;
    exp_t e;
    @(posedge clk); #1;
    frame_start = fs; line_start = ls; in_valid = v; in_data = d; inv = iv;
    if (fs) begin
      if (m_fcnt == P - 1) begin
        m_fcnt = 0;
`ifdef GLDP_FRC_SUPERFRAME_INV_EN
        m_sinv = m_sinv ^ 1;
`endif
      end else begin
        m_fcnt = m_fcnt + 1;
      end
      m_ypar = 0;
      m_xpar = 0;
    end else if (ls) begin
      m_ypar = m_ypar ^ 1;
      m_xpar = 0;
    end
    if (v) begin
      s  = m_xpar ^ m_ypar ^ int'(iv) ^ m_sinv;
      fe = (m_fcnt + (s != 0 ? P / 2 : 0)) % P;
      for (int c = 0; c < CH; c++) begin
        lv = int'(d[c*IN_W +: IN_W]);
        r  = (fe * lv) % P;
        b[c] = ((r + lv) >= P);
      end
      e.due = cyc + 3;
      e.bits = b;
      exp_q.push_back(e);
      m_xpar = m_xpar ^ 1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) px(1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    frame_start = 1'b0; line_start = 1'b0; in_valid = 1'b0; inv = 1'b0; in_data = '0;
    exp_q.delete();
    last_exp = '0;
    m_fcnt = 0; m_ypar = 0; m_xpar = 0; m_sinv = 0;
    #1;
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_out_dither", 32'(out_dither), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_frames(input int nfr, input int nline, input int npix, input logic [IN_W-1:0] lvl);
    for (int f = 0; f < nfr; f++)
      for (int y = 0; y < nline; y++)
        for (int x = 0; x < npix; x++)
          px((y == 0) && (x == 0), (y != 0) && (x == 0), 1'b1, {CH{lvl}}, 1'b0);
    idle(5);
  endtask

  // scoreboard: compares DUT outputs with the model every cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_dither", 32'(out_dither), 0);
    end else begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        n_checks++;
        n_errors++;
        $display("FAIL missing_output actual=none required=valid_at_%0d t=%0t", exp_q[0].due, $time);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        cmp_e = exp_q.pop_front();
        check("out_valid", 32'(out_valid), 1);
        check("out_dither", 32'(out_dither), 32'(cmp_e.bits));
        last_exp = cmp_e.bits;
        if (out_valid) act_q.push_back(out_dither);
      end else begin
        check("idle_out_valid", 32'(out_valid), 0);
        check("hold_out_dither", 32'(out_dither), 32'(last_exp));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, n0, n1, pos0, pos1, ok_a, ok_b, k2;
    int pos[$];
    logic [30:0] b0, b1;

    do_reset();

    // latency and same-cycle update: fcnt becomes 1, fe=1, L=16 -> 16+16>=31
    act_q.delete();
    px(1'b1, 1'b1, 1'b1, {CH{5'd16}}, 1'b0);
    idle(2);
    check("lat_early_valid", 32'(out_valid), 0);
    idle(1);
    check("lat_on_valid", 32'(out_valid), 1);
    check("lat_on_dither", 32'(out_dither), 32'h7);
    idle(4);

    // extremes
    act_q.delete();
    run_frames(62, 2, 2, 5'd0);
    bad = 0;
    foreach (act_q[i]) if (act_q[i] !== 3'b000) bad++;
    check("ext_l0_nonzero", bad, 0);
    check("ext_l0_count", act_q.size(), 248);
    act_q.delete();
    run_frames(62, 2, 2, 5'd31);
    bad = 0;
    foreach (act_q[i]) if (act_q[i] !== 3'b111) bad++;
    check("ext_l31_notone", bad, 0);
    check("ext_l31_count", act_q.size(), 248);

    // L=1 at (0,0) and (1,0) over one period, frame j has fcnt = j mod 31
    do_reset();
    act_q.delete();
    run_frames(31, 1, 2, 5'd1);
    n0 = 0; n1 = 0; pos0 = -1; pos1 = -1;
    for (int j = 0; j < 31; j++) begin
      if (act_q[2*j][0]) begin n0++; pos0 = (j + 1) % P; end
      if (act_q[2*j+1][0]) begin n1++; pos1 = (j + 1) % P; end
    end
    check("l1_size", act_q.size(), 62);
    check("l1_p0_ones", n0, 1);
    check("l1_p0_fcnt", pos0, 30);
    check("l1_p1_ones", n1, 1);
    check("l1_p1_fcnt", pos1, 15);

    // L=10 on adjacent pixels over a wrap-aligned period (fcnt 0..30)
    do_reset();
    for (int j = 0; j < 30; j++) px(1'b1, 1'b0, 1'b0, '0, 1'b0);
    act_q.delete();
    run_frames(31, 1, 2, 5'd10);
    for (int k = 0; k < 31; k++) begin
      b0[k] = act_q[2*k][0];
      b1[k] = act_q[2*k+1][0];
    end
    check("l10_p0_ones", $countones(b0), 10);
    check("l10_p1_ones", $countones(b1), 10);
    ok_a = 1; ok_b = 1;
    for (int k = 0; k < 31; k++) begin
      k2 = (k + 15) % P;
      if (b1[k] != b0[k2]) ok_a = 0;
      if (b0[k] != b1[k2]) ok_b = 0;
    end
    check("l10_rotation15", ok_a | ok_b, 1);

    // superframe behaviour over two periods
    do_reset();
    act_q.delete();
    run_frames(62, 1, 1, 5'd1);
    pos.delete();
    for (int j = 0; j < 62; j++) if (act_q[j][0]) pos.push_back(j + 1);
    check("sf_ones", pos.size(), 2);
    if (pos.size() == 2) begin
      check("sf_first_frame", pos[0], 30);
`ifdef GLDP_FRC_SUPERFRAME_INV_EN
      check("sf_second_frame", pos[1], 31 + 15);
`else
      check("sf_second_frame", pos[1], 31 + 30);
`endif
    end

    // randomized traffic with a mid-stream reset
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      px($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
         (CH*IN_W)'($urandom()), 1'($urandom_range(0, 1)));
    end
    idle(6);
    check("drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
